// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_if
// Description : Read, write and clear-control bundle for the LEGv8 register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_drop;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data1, rd_data2, clr_busy, clr_done, wr_drop
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
        output rd_data1, rd_data2, clr_busy, clr_done, wr_drop
    );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32 x 64-bit LEGv8 register file, two combinational reads, one
//               clocked write, hard-wired XZR and a one-register-per-cycle clear.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    reg_file_if.slave  bus
);
    localparam int                NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    // The hard-wired register sits at the top index, so the sweep stops one short
    localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(NUM_REGS - 2);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic              r_done;
    logic              r_drop;

    logic [DATA_W-1:0] w_regs [NUM_REGS];
    logic              w_wr_ok;
    logic              w_wr_lost;
    logic              w_fwd1;
    logic              w_fwd2;

    assign w_wr_ok   = bus.wr_en && (bus.wr_addr != ZERO_IDX) && !r_busy;
    assign w_wr_lost = bus.wr_en && (bus.wr_addr != ZERO_IDX) &&  r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_drop <= w_wr_lost;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + PTR_ONE;
                    if (r_ptr == LAST_CLR) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_live
            logic [DATA_W-1:0] r_q;
            // Clear and architectural write are mutually exclusive: writes need !r_busy
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (r_busy && (r_ptr == ADDR_W'(i))) begin
                    r_q <= '0;
                end else if (w_wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
                    r_q <= bus.wr_data;
                end
            end
            assign w_regs[i] = r_q;
        end
    end

    assign w_fwd1 = (BYPASS != 0) && bus.wr_en && !r_busy && (bus.wr_addr == bus.rd_addr1);
    assign w_fwd2 = (BYPASS != 0) && bus.wr_en && !r_busy && (bus.wr_addr == bus.rd_addr2);

    always_comb begin
        bus.rd_data1 = w_regs[bus.rd_addr1];
        if (bus.rd_addr1 == ZERO_IDX) begin
            bus.rd_data1 = '0;
        end else if (w_fwd1) begin
            bus.rd_data1 = bus.wr_data;
        end
    end

    always_comb begin
        bus.rd_data2 = w_regs[bus.rd_addr2];
        if (bus.rd_addr2 == ZERO_IDX) begin
            bus.rd_data2 = '0;
        end else if (w_fwd2) begin
            bus.rd_data2 = bus.wr_data;
        end
    end

    assign bus.clr_busy = r_busy;
    assign bus.clr_done = r_done;
    assign bus.wr_drop  = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Scoreboard bench for reg_file, bypassing and non-bypassing builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_if #(.DATA_W(64), .ADDR_W(5)) bus ();
    reg_file_if #(.DATA_W(64), .ADDR_W(5)) bus_nb ();

    assign bus_nb.rd_addr1 = bus.rd_addr1;
    assign bus_nb.rd_addr2 = bus.rd_addr2;
    assign bus_nb.wr_en    = bus.wr_en;
    assign bus_nb.wr_addr  = bus.wr_addr;
    assign bus_nb.wr_data  = bus.wr_data;
    assign bus_nb.clr_req  = bus.clr_req;

    reg_file #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    reg_file #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .bus(bus_nb)
    );

    logic [63:0] sb [$];
    logic [63:0] exp;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        #20;
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr1 = 5'(i);
            bus.rd_addr2 = 5'(31 - i);
            sb.push_back(64'h0);
            sb.push_back(64'h0);
            #1;
            exp = sb.pop_front(); n_cmp++;
            if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL rst_rd1[%0d]: got %h want %h", i, bus.rd_data1, exp); end
            exp = sb.pop_front(); n_cmp++;
            if (bus.rd_data2 !== exp) begin n_err++; $display("FAIL rst_rd2[%0d]: got %h want %h", 31 - i, bus.rd_data2, exp); end
        end
        sb.push_back(64'h0); sb.push_back(64'h0); sb.push_back(64'h0);
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.clr_busy} !== exp) begin n_err++; $display("FAIL rst_busy: got %b want %h", bus.clr_busy, exp); end
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.clr_done} !== exp) begin n_err++; $display("FAIL rst_done: got %b want %h", bus.clr_done, exp); end
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.wr_drop} !== exp) begin n_err++; $display("FAIL rst_drop: got %b want %h", bus.wr_drop, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_bypass;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd5;
        bus.wr_data  = 64'hDEAD_BEEF_0000_0001;
        bus.rd_addr1 = 5'd5;
        sb.push_back(64'hDEAD_BEEF_0000_0001);
        sb.push_back(64'h0);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL bypass_same: got %h want %h", bus.rd_data1, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (bus_nb.rd_data1 !== exp) begin n_err++; $display("FAIL nobypass_same: got %h want %h", bus_nb.rd_data1, exp); end
        tick();
        bus.wr_en = 1'b0;
        sb.push_back(64'hDEAD_BEEF_0000_0001);
        sb.push_back(64'hDEAD_BEEF_0000_0001);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL wr_next: got %h want %h", bus.rd_data1, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (bus_nb.rd_data1 !== exp) begin n_err++; $display("FAIL wr_next_nb: got %h want %h", bus_nb.rd_data1, exp); end
    endtask

    task automatic test_zero_reg;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd31;
        bus.wr_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.rd_addr2 = 5'd31;
        sb.push_back(64'h0);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data2 !== exp) begin n_err++; $display("FAIL xzr_same: got %h want %h", bus.rd_data2, exp); end
        tick();
        bus.wr_en = 1'b0;
        sb.push_back(64'h0);
        sb.push_back(64'h0);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data2 !== exp) begin n_err++; $display("FAIL xzr_next: got %h want %h", bus.rd_data2, exp); end
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.wr_drop} !== exp) begin n_err++; $display("FAIL xzr_drop: got %b want %h", bus.wr_drop, exp); end
    endtask

    task automatic test_clear;
        int busy_cycles;
        for (int i = 0; i < 31; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 5'(i);
            bus.wr_data = 64'(i + 1);
            tick();
        end
        bus.wr_en    = 1'b0;
        bus.rd_addr1 = 5'd30;
        bus.rd_addr2 = 5'd0;
        sb.push_back(64'd31);
        sb.push_back(64'd1);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL fill_x30: got %h want %h", bus.rd_data1, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data2 !== exp) begin n_err++; $display("FAIL fill_x0: got %h want %h", bus.rd_data2, exp); end

        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            if (!bus.clr_busy) break;
            if (c == 0) begin
                bus.rd_addr1 = 5'd0;
                sb.push_back(64'd1);
                #1;
                exp = sb.pop_front(); n_cmp++;
                if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL clr_old_x0: got %h want %h", bus.rd_data1, exp); end
            end
            if (c == 2) begin
                bus.wr_en    = 1'b1;
                bus.wr_addr  = 5'd7;
                bus.wr_data  = 64'h1234;
                bus.rd_addr2 = 5'd7;
                sb.push_back(64'd8);
                #1;
                exp = sb.pop_front(); n_cmp++;
                if (bus.rd_data2 !== exp) begin n_err++; $display("FAIL clr_no_bypass: got %h want %h", bus.rd_data2, exp); end
            end
            if (c == 3) begin
                sb.push_back(64'h1);
                exp = sb.pop_front(); n_cmp++;
                if ({63'b0, bus.wr_drop} !== exp) begin n_err++; $display("FAIL clr_wr_drop: got %b want %h", bus.wr_drop, exp); end
            end
            busy_cycles++;
            tick();
            bus.wr_en = 1'b0;
        end
        sb.push_back(64'd31);
        sb.push_back(64'h1);
        exp = sb.pop_front(); n_cmp++;
        if (64'(busy_cycles) !== exp) begin n_err++; $display("FAIL clr_busy_len: got %0d want %0d", busy_cycles, exp); end
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.clr_done} !== exp) begin n_err++; $display("FAIL clr_done_pulse: got %b want %h", bus.clr_done, exp); end

        // Write issued in the DONE cycle must be kept
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 64'h55;
        tick();
        bus.wr_en = 1'b0;
        sb.push_back(64'h0);
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.clr_done} !== exp) begin n_err++; $display("FAIL clr_done_once: got %b want %h", bus.clr_done, exp); end
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr1 = 5'(i);
            sb.push_back((i == 7) ? 64'h55 : 64'h0);
            #1;
            exp = sb.pop_front(); n_cmp++;
            if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL post_clr[%0d]: got %h want %h", i, bus.rd_data1, exp); end
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd10;
        bus.wr_data = 64'hAAAA;
        tick();
        bus.wr_addr  = 5'd11;
        bus.wr_data  = 64'hBBBB;
        bus.rd_addr1 = 5'd10;
        bus.rd_addr2 = 5'd11;
        sb.push_back(64'hAAAA);
        sb.push_back(64'hBBBB);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL b2b_prev: got %h want %h", bus.rd_data1, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data2 !== exp) begin n_err++; $display("FAIL b2b_fwd: got %h want %h", bus.rd_data2, exp); end
        tick();

        // Write and clear request land on the same edge
        bus.wr_addr = 5'd9;
        bus.wr_data = 64'h42;
        bus.clr_req = 1'b1;
        tick();
        bus.wr_en    = 1'b0;
        bus.clr_req  = 1'b0;
        bus.rd_addr1 = 5'd9;
        sb.push_back(64'h42);
        sb.push_back(64'h1);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL wr_with_clr: got %h want %h", bus.rd_data1, exp); end
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.clr_busy} !== exp) begin n_err++; $display("FAIL wr_with_clr_busy: got %b want %h", bus.clr_busy, exp); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.clr_done) begin seen = 1'b1; break; end
            tick();
        end
        tick();
        sb.push_back(64'h1);
        sb.push_back(64'h0);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, seen} !== exp) begin n_err++; $display("FAIL b2b_done_seen: got %b want %h", seen, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL b2b_x9_cleared: got %h want %h", bus.rd_data1, exp); end
    endtask

    task automatic test_reset_mid_clear;
        int done_cnt;
        bit seen;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd20;
        bus.wr_data = 64'hAB;
        tick();
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        #2;
        rst_n = 1'b0;
        bus.rd_addr1 = 5'd20;
        sb.push_back(64'h0);
        sb.push_back(64'h0);
        sb.push_back(64'h0);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.clr_busy} !== exp) begin n_err++; $display("FAIL rst_mid_busy: got %b want %h", bus.clr_busy, exp); end
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, bus.clr_done} !== exp) begin n_err++; $display("FAIL rst_mid_done: got %b want %h", bus.clr_done, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL rst_mid_x20: got %h want %h", bus.rd_data1, exp); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.clr_done) done_cnt++;
        end
        sb.push_back(64'h0);
        exp = sb.pop_front(); n_cmp++;
        if (64'(done_cnt) !== exp) begin n_err++; $display("FAIL rst_mid_no_done: got %0d want %0d", done_cnt, exp); end

        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_data = 64'h99;
        tick();
        bus.wr_addr = 5'd1;
        bus.wr_data = 64'h77;
        tick();
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        tick();
        bus.rd_addr1 = 5'd0;
        bus.rd_addr2 = 5'd1;
        sb.push_back(64'h0);
        sb.push_back(64'h77);
        #1;
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data1 !== exp) begin n_err++; $display("FAIL restart_x0: got %h want %h", bus.rd_data1, exp); end
        exp = sb.pop_front(); n_cmp++;
        if (bus.rd_data2 !== exp) begin n_err++; $display("FAIL restart_x1: got %h want %h", bus.rd_data2, exp); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.clr_done) begin seen = 1'b1; break; end
            tick();
        end
        sb.push_back(64'h1);
        exp = sb.pop_front(); n_cmp++;
        if ({63'b0, seen} !== exp) begin n_err++; $display("FAIL restart_done: got %b want %h", seen, exp); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_clear();
        test_back_to_back();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
